// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution psum collector and its controller.
// Holds width defaults, the collector state encoding and a width-generic saturating add.
package conv_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int SAT_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } coll_state_t;

  // Result is {overflow, value}; the value clamps at 2^w-1 for any w up to SAT_W.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                             input logic [SAT_W-1:0] b,
                                             input int               w);
    logic [SAT_W:0] lim;
    logic [SAT_W:0] sum;
    lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
    sum = {1'b0, a} + {1'b0, b};
    if (sum > lim) return {1'b1, lim[SAT_W-1:0]};
    return {1'b0, sum[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/psum_acc_cell.sv
// One saturating accumulator for a single output pixel.
// Latency: value updates the cycle after add_en; clear wins over add_en.
// Backpressure: none, the owner gates add_en.
module psum_acc_cell
  import conv_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             add_en,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] value,
  output logic             sat
);

  logic [SAT_W:0] res;
  logic           unused_res;

  assign res        = sat_add(SAT_W'(value), SAT_W'(addend), ACC_W);
  assign sat        = add_en & res[SAT_W];
  assign unused_res = ^res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (add_en) begin
      value <= res[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/conv_psum_collector.sv
// Accumulates systolic column psums over PASSES tile passes into a 2x2 map, scales and clamps to DATA_W.
// Latency: result valid one cycle after the final accepted beat.
// Backpressure: result held with in_ready low until out_ready.
module conv_psum_collector
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ROWS   = 2,
  parameter int PASSES = 5,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              psum_valid,
  input  logic [DATA_W-1:0] psum_in1,
  input  logic [DATA_W-1:0] psum_in2,
  output logic              in_ready,
  output logic [DATA_W-1:0] conv_out_11,
  output logic [DATA_W-1:0] conv_out_12,
  output logic [DATA_W-1:0] conv_out_21,
  output logic [DATA_W-1:0] conv_out_22,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              sat_flag
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);
  localparam logic [PW-1:0]    PASS_LAST = PW'(PASSES - 1);
  localparam logic [ACC_W-1:0] PIX_MAX   = ACC_W'({DATA_W{1'b1}});

  coll_state_t state, state_nxt;
  logic clr, load, accept, last_beat;
  logic [RW-1:0] row_cnt;
  logic [PW-1:0] pass_cnt;

  logic [ACC_W-1:0]  addend  [2];
  logic [ACC_W-1:0]  acc_val [ROWS][2];
  logic [DATA_W-1:0] pix_nxt [ROWS][2];
  logic [DATA_W-1:0] pix_q   [ROWS][2];
  logic [ROWS*2-1:0] cell_sat;
  logic [ROWS*2-1:0] clamp;

  assign addend[0] = ACC_W'(psum_in1);
  assign addend[1] = ACC_W'(psum_in2);

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = psum_valid & in_ready & ~start;
  assign last_beat = accept && (row_cnt == ROW_LAST) && (pass_cnt == PASS_LAST);

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (start) begin
          clr = 1'b1;
        end else if (last_beat) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < 2; c++) begin : g_col
      logic             row_hit;
      logic [SAT_W:0]   sum_fin;
      logic [ACC_W-1:0] acc_fin;
      logic [ACC_W-1:0] acc_shr;
      logic             unused_sum;

      assign row_hit = accept && (row_cnt == RW'(r));

      psum_acc_cell #(.ACC_W(ACC_W)) u_cell (
        .clk    (clk),
        .rst    (rst),
        .clear  (clr),
        .add_en (row_hit),
        .addend (addend[c]),
        .value  (acc_val[r][c]),
        .sat    (cell_sat[r*2+c])
      );

      // The final beat's sum must reach the output registers on the same edge it lands in the cell.
      assign sum_fin    = sat_add(SAT_W'(acc_val[r][c]), SAT_W'(addend[c]), ACC_W);
      assign unused_sum = ^sum_fin;
      assign acc_fin    = row_hit ? sum_fin[ACC_W-1:0] : acc_val[r][c];
      assign acc_shr    = acc_fin >> SHIFT;
      assign clamp[r*2+c] = (acc_shr > PIX_MAX);
      assign pix_nxt[r][c] = clamp[r*2+c] ? {DATA_W{1'b1}} : acc_shr[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt  <= '0;
      pass_cnt <= '0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < 2; c++) begin
          pix_q[r][c] <= '0;
        end
      end
    end else begin
      done <= load;
      if (clr) begin
        row_cnt  <= '0;
        pass_cnt <= '0;
      end else if (accept) begin
        if (row_cnt == ROW_LAST) begin
          row_cnt  <= '0;
          pass_cnt <= pass_cnt + 1'b1;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end

      if (clr) begin
        sat_flag <= 1'b0;
      end else if ((|cell_sat) || (load && (|clamp))) begin
        sat_flag <= 1'b1;
      end

      if (load) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < 2; c++) begin
            pix_q[r][c] <= pix_nxt[r][c];
          end
        end
      end
    end
  end

  assign conv_out_11 = pix_q[0][0];
  assign conv_out_12 = pix_q[0][1];
  assign conv_out_21 = pix_q[1][0];
  assign conv_out_22 = pix_q[1][1];

endmodule

// File: tb/tb_conv_psum_collector.sv
// Bench for conv_psum_collector: two instances (SHIFT 0 and 1) share stimulus and a result-level model.
module tb_conv_psum_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       psum_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] psum_in1 = 8'd0;
  logic [7:0] psum_in2 = 8'd0;

  logic       in_ready [2];
  logic       out_valid[2];
  logic       done     [2];
  logic       sat_flag [2];
  logic [7:0] c11[2], c12[2], c21[2], c22[2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_psum_collector #(.DATA_W(8), .ACC_W(16), .ROWS(2), .PASSES(2), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .psum_valid(psum_valid),
    .psum_in1(psum_in1), .psum_in2(psum_in2), .in_ready(in_ready[0]),
    .conv_out_11(c11[0]), .conv_out_12(c12[0]), .conv_out_21(c21[0]), .conv_out_22(c22[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .done(done[0]), .sat_flag(sat_flag[0])
  );

  conv_psum_collector #(.DATA_W(8), .ACC_W(16), .ROWS(2), .PASSES(2), .SHIFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .psum_valid(psum_valid),
    .psum_in1(psum_in1), .psum_in2(psum_in2), .in_ready(in_ready[1]),
    .conv_out_11(c11[1]), .conv_out_12(c12[1]), .conv_out_21(c21[1]), .conv_out_22(c22[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .done(done[1]), .sat_flag(sat_flag[1])
  );

  // Result-level model: collecting / holding, a beat count and integer sums.
  localparam int ROWS = 2;
  localparam int PASSES = 2;
  logic       m_coll = 1'b0;
  logic       m_hold = 1'b0;
  logic       m_done = 1'b0;
  logic [1:0] m_sat = 2'b00;
  int         m_n = 0;
  int         m_s[4] = '{default: 0};
  int         m_pix[2][4] = '{default: 0};

  always @(posedge clk or negedge rst) begin : model
    int s[4];
    int pix[2][4];
    logic [1:0] ns;
    logic acc_cap;
    int r;
    int v;
    if (!rst) begin
      m_coll <= 1'b0;
      m_hold <= 1'b0;
      m_done <= 1'b0;
      m_sat  <= 2'b00;
      m_n    <= 0;
      m_s    <= '{default: 0};
      m_pix  <= '{default: 0};
    end else begin
      m_done <= 1'b0;
      if (m_hold) begin
        if (out_ready) m_hold <= 1'b0;
      end else if (start) begin
        m_s    <= '{default: 0};
        m_n    <= 0;
        m_sat  <= 2'b00;
        m_coll <= 1'b1;
      end else if (m_coll && psum_valid) begin
        s = m_s;
        r = m_n % ROWS;
        s[r*2]   = s[r*2] + int'(psum_in1);
        s[r*2+1] = s[r*2+1] + int'(psum_in2);
        acc_cap = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (s[i] > 65535) begin
            s[i] = 65535;
            acc_cap = 1'b1;
          end
        end
        ns = m_sat | {acc_cap, acc_cap};
        m_s <= s;
        m_n <= m_n + 1;
        if (m_n + 1 == ROWS * PASSES) begin
          pix = m_pix;
          for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
              v = s[i] / (1 << k);
              if (v > 255) begin
                v = 255;
                ns[k] = 1'b1;
              end
              pix[k][i] = v;
            end
          end
          m_pix  <= pix;
          m_coll <= 1'b0;
          m_hold <= 1'b1;
          m_done <= 1'b1;
        end
        m_sat <= ns;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dpix(input int k);
    return {c11[k], c12[k], c21[k], c22[k]};
  endfunction

  function automatic logic [31:0] mpix(input int k);
    return {8'(m_pix[k][0]), 8'(m_pix[k][1]), 8'(m_pix[k][2]), 8'(m_pix[k][3])};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("cycle_dut%0d", k),
          {28'd0, in_ready[k], out_valid[k], done[k], sat_flag[k], dpix(k)},
          {28'd0, m_coll, m_hold, m_done, m_sat[k], mpix(k)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b);
    psum_valid = 1'b1;
    psum_in1 = a;
    psum_in2 = b;
    tick();
    psum_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Literal expectations pin both the DUT and the model.
  task automatic lit(input string name, input int k, input logic [31:0] exp_pix, input logic exp_sat);
    chk({name, "_pix"}, {32'd0, dpix(k)}, {32'd0, exp_pix});
    chk({name, "_model"}, {32'd0, mpix(k)}, {32'd0, exp_pix});
    chk({name, "_sat"}, {63'd0, sat_flag[k]}, {63'd0, exp_sat});
  endtask

  initial begin
    int gap;
    #12 rst = 1'b1;
    idle(2);

    // Basic accumulation
    do_start();
    beat(8'd10, 8'd20);
    beat(8'd30, 8'd40);
    beat(8'd1, 8'd2);
    beat(8'd3, 8'd4);
    chk("basic_valid_done", {62'd0, out_valid[0], done[0]}, 64'd3);
    lit("basic_s0", 0, {8'd11, 8'd22, 8'd33, 8'd44}, 1'b0);
    lit("basic_s1", 1, {8'd5, 8'd11, 8'd16, 8'd22}, 1'b0);
    tick();
    chk("basic_done_pulse", {62'd0, out_valid[0], done[0]}, 64'd2);
    release_out();
    chk("basic_release", {62'd0, out_valid[0], in_ready[0]}, 64'd0);

    // Output saturation
    do_start();
    beat(8'd200, 8'd5);
    beat(8'd0, 8'd0);
    beat(8'd100, 8'd5);
    beat(8'd0, 8'd0);
    lit("sat_s0", 0, {8'd255, 8'd10, 8'd0, 8'd0}, 1'b1);
    lit("sat_s1", 1, {8'd150, 8'd5, 8'd0, 8'd0}, 1'b0);
    release_out();

    // Backpressure
    do_start();
    beat(8'd5, 8'd6);
    beat(8'd7, 8'd8);
    beat(8'd9, 8'd10);
    beat(8'd11, 8'd12);
    for (int i = 0; i < 5; i++) begin
      psum_valid = 1'b1;
      psum_in1 = 8'd99;
      psum_in2 = 8'd99;
      start = (i % 2 == 0);
      tick();
    end
    start = 1'b0;
    psum_valid = 1'b0;
    chk("bp_hold", {62'd0, in_ready[0], out_valid[0]}, 64'd1);
    lit("bp_s0", 0, {8'd14, 8'd16, 8'd18, 8'd20}, 1'b0);
    release_out();
    chk("bp_to_idle", {63'd0, out_valid[0]}, 64'd0);
    release_out();
    chk("bp_idle_ready", {62'd0, in_ready[0], out_valid[0]}, 64'd0);

    // Restart mid-accumulation
    do_start();
    beat(8'd4, 8'd4);
    beat(8'd4, 8'd4);
    beat(8'd4, 8'd4);
    start = 1'b1;
    psum_valid = 1'b1;
    psum_in1 = 8'd99;
    psum_in2 = 8'd99;
    tick();
    start = 1'b0;
    psum_valid = 1'b0;
    for (int i = 0; i < 4; i++) beat(8'd1, 8'd1);
    lit("restart_s0", 0, {8'd2, 8'd2, 8'd2, 8'd2}, 1'b0);
    lit("restart_s1", 1, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b0);
    release_out();

    // Reset mid-operation, asserted between clock edges
    do_start();
    beat(8'd1, 8'd1);
    beat(8'd2, 8'd2);
    #2 rst = 1'b0;
    #1;
    chk("rst_ctrl", {60'd0, in_ready[0], out_valid[0], done[0], sat_flag[0]}, 64'd0);
    chk("rst_pix0", {32'd0, dpix(0)}, 64'd0);
    chk("rst_pix1", {32'd0, dpix(1)}, 64'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    beat(8'd7, 8'd7);
    beat(8'd7, 8'd7);
    chk("rst_ignore", {62'd0, in_ready[0], out_valid[0]}, 64'd0);

    // Stalls: random gaps between beats
    do_start();
    beat(8'd10, 8'd20);
    idle($urandom_range(1, 3));
    beat(8'd30, 8'd40);
    idle($urandom_range(1, 3));
    beat(8'd1, 8'd2);
    gap = $urandom_range(1, 3);
    idle(gap);
    chk("stall_not_early", {63'd0, out_valid[0]}, 64'd0);
    beat(8'd3, 8'd4);
    chk("stall_valid_done", {62'd0, out_valid[0], done[0]}, 64'd3);
    lit("stall_s0", 0, {8'd11, 8'd22, 8'd33, 8'd44}, 1'b0);
    release_out();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
